// File: rtl/br_delay_valid_next_rr_sched.sv
// Round-robin scheduler feeding a fixed-latency delay line that announces valid one cycle
// ahead of the data, with an optional forced idle gap after each grant.
module br_delay_valid_next_rr_sched #(
    parameter int NumRequesters = 2,
    parameter int BitWidth      = 1,
    parameter int NumStages     = 1,
    parameter int MinGap        = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NumRequesters-1:0]           push_valid,
    output logic [NumRequesters-1:0]           push_ready,
    input  logic [NumRequesters*BitWidth-1:0]  push_data,
    output logic                               out_valid_next,
    output logic [BitWidth-1:0]                out,
    output logic [$clog2(NumRequesters)-1:0]   out_src,
    output logic                               busy
);
    localparam int SrcW = $clog2(NumRequesters);
    localparam int GapW = (MinGap > 0) ? $clog2(MinGap + 1) : 1;

    logic [SrcW-1:0]      r_last;
    logic [GapW-1:0]      r_gap;
    logic [NumRequesters-1:0] w_ready;
    logic                 w_any;
    logic [SrcW-1:0]      w_idx;
    logic [BitWidth-1:0]  w_grant_data;
    logic [NumStages:0]   w_vn;
    logic                 w_launch_valid;
    int                   v_idx;

    // Scan starts one past the last winner; the gate on rst_n keeps reset cycles grant-free.
    always_comb begin
        w_ready = '0;
        w_any   = 1'b0;
        w_idx   = '0;
        v_idx   = 0;
        if (rst_n && (r_gap == '0)) begin
            for (int k = 1; k <= NumRequesters; k++) begin
                v_idx = (int'(r_last) + k) % NumRequesters;
                if (!w_any && push_valid[v_idx]) begin
                    w_any          = 1'b1;
                    w_idx          = SrcW'(v_idx);
                    w_ready[v_idx] = 1'b1;
                end
            end
        end
    end

    assign push_ready   = w_ready;
    assign w_grant_data = push_data[int'(w_idx)*BitWidth +: BitWidth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SrcW'(NumRequesters - 1);
            r_gap  <= '0;
        end else begin
            if (w_any) begin
                r_last <= w_idx;
                r_gap  <= GapW'(MinGap);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    generate
        if (NumStages == 0) begin : g_no_delay
            logic r_launch_valid;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_launch_valid <= 1'b0;
                else        r_launch_valid <= w_any;
            end
            assign w_vn           = w_any;
            assign w_launch_valid = r_launch_valid;
        end else begin : g_delay
            logic [NumStages:1] r_vn;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vn <= '0;
                end else begin
                    r_vn[1] <= w_any;
                    for (int k = 2; k <= NumStages; k++) r_vn[k] <= r_vn[k-1];
                end
            end
            assign w_vn           = {r_vn, w_any};
            assign w_launch_valid = r_vn[1];
        end
    endgenerate

    // Payload registers are left unreset; each stage only moves when its valid bit says so.
    genvar gi;
    generate
        for (gi = 0; gi <= NumStages; gi++) begin : g_stage
            logic [BitWidth-1:0] r_data;
            logic [SrcW-1:0]     r_src;
            if (gi == 0) begin : g_launch
                always_ff @(posedge clk) begin
                    if (w_any) begin
                        r_data <= w_grant_data;
                        r_src  <= w_idx;
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk) begin
                    if (w_vn[gi]) begin
                        r_data <= g_stage[gi-1].r_data;
                        r_src  <= g_stage[gi-1].r_src;
                    end
                end
            end
        end
    endgenerate

    assign out_valid_next = w_vn[NumStages];
    assign out            = g_stage[NumStages].r_data;
    assign out_src        = g_stage[NumStages].r_src;
    assign busy           = (|w_vn) | w_launch_valid | (r_gap != '0);

endmodule

// File: tb/tb_br_delay_valid_next_rr_sched.sv
// Drives three scheduler variants (different depth/gap) with shared stimulus and checks each
// cycle against a history-based reference of grants, latency and busy.
module tb_br_delay_valid_next_rr_sched;
    localparam int NI = 3;
    localparam int HN = 4096;
    localparam int SP [NI] = '{2, 0, 3};
    localparam int GP [NI] = '{0, 2, 1};

    logic        clk;
    logic        rst_n;
    logic [3:0]  push_valid;
    logic [31:0] push_data;
    logic [3:0]  rdy  [NI];
    logic        ovn  [NI];
    logic [7:0]  dout [NI];
    logic [1:0]  dsrc [NI];
    logic        bsy  [NI];

    int          hidx [NI][HN];
    logic [7:0]  hdat [NI][HN];
    int          last_g [NI];
    int          gap [NI];
    int          waitc [NI][4];
    int          cyc;
    int          total;
    int          bad;

    br_delay_valid_next_rr_sched #(.NumRequesters(4), .BitWidth(8), .NumStages(2), .MinGap(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(rdy[0]), .push_data(push_data),
        .out_valid_next(ovn[0]), .out(dout[0]), .out_src(dsrc[0]), .busy(bsy[0]));
    br_delay_valid_next_rr_sched #(.NumRequesters(4), .BitWidth(8), .NumStages(0), .MinGap(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(rdy[1]), .push_data(push_data),
        .out_valid_next(ovn[1]), .out(dout[1]), .out_src(dsrc[1]), .busy(bsy[1]));
    br_delay_valid_next_rr_sched #(.NumRequesters(4), .BitWidth(8), .NumStages(3), .MinGap(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(rdy[2]), .push_data(push_data),
        .out_valid_next(ovn[2]), .out(dout[2]), .out_src(dsrc[2]), .busy(bsy[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s inst%0d cyc%0d got=%0h exp=%0h", tag, inst, cyc, got, exp);
        end
    endtask

    // One clock cycle: apply inputs mid-cycle, predict from grant history, compare, advance model.
    task automatic step(input bit rst_low, input logic [3:0] pv, input logic [31:0] pd);
        int       g;
        int       idx;
        int       lo;
        int       back;
        logic [3:0] exp_rdy;
        logic     bexp;
        @(negedge clk);
        rst_n      = ~rst_low;
        push_valid = pv;
        push_data  = pd;
        #1;
        for (int i = 0; i < NI; i++) begin
            g = -1;
            if (rst_low) begin
                for (int t = 0; t <= cyc; t++) hidx[i][t] = -1;
                last_g[i] = 3;
                gap[i]    = 0;
                for (int j = 0; j < 4; j++) waitc[i][j] = 0;
            end else if (gap[i] == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    idx = (last_g[i] + k) % 4;
                    if (g < 0 && pv[idx]) g = idx;
                end
            end
            hidx[i][cyc] = g;
            hdat[i][cyc] = (g >= 0) ? pd[g*8 +: 8] : 8'h00;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
            chk("push_ready", i, 32'(rdy[i]), 32'(exp_rdy));

            back = cyc - SP[i];
            chk("out_valid_next", i, 32'(ovn[i]), 32'((back >= 0) && (hidx[i][back] >= 0)));

            bexp = (gap[i] != 0);
            lo = cyc - ((SP[i] > 0) ? SP[i] : 1);
            if (lo < 0) lo = 0;
            for (int t = lo; t <= cyc; t++) if (hidx[i][t] >= 0) bexp = 1'b1;
            chk("busy", i, 32'(bsy[i]), 32'(bexp));

            back = cyc - SP[i] - 1;
            if (back >= 0 && hidx[i][back] >= 0) begin
                chk("out", i, 32'(dout[i]), 32'(hdat[i][back]));
                chk("out_src", i, 32'(dsrc[i]), 32'(hidx[i][back]));
            end

            if (!rst_low && $countones(rdy[i]) == 1) begin
                for (int j = 0; j < 4; j++) begin
                    if (rdy[i][j] || !pv[j]) waitc[i][j] = 0;
                    else waitc[i][j]++;
                    total++;
                    assert (waitc[i][j] <= 3) else begin
                        bad++;
                        $error("FAIL starvation inst%0d req%0d skipped=%0d limit=3", i, j, waitc[i][j]);
                    end
                end
            end

            if (!rst_low) begin
                if (g >= 0) begin
                    last_g[i] = g;
                    gap[i]    = GP[i];
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        push_valid = '0;
        push_data  = '0;
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < HN; t++) hidx[i][t] = -1;
            last_g[i] = 3;
            gap[i]    = 0;
            for (int j = 0; j < 4; j++) waitc[i][j] = 0;
        end

        // reset held with requests present: nothing may be granted
        repeat (3) step(1'b1, 4'hF, $urandom);

        // everyone requesting continuously: rotation 0,1,2,3,... with per-variant gaps
        repeat (16) step(1'b0, 4'hF, $urandom);

        // lone request from requester 0 carrying 0x0A, then drain
        step(1'b0, 4'b0001, 32'h0000_000A);
        repeat (6) step(1'b0, 4'h0, 32'h0);

        // single persistent requester exposes the idle gap
        repeat (8) step(1'b0, 4'b0100, $urandom);
        repeat (5) step(1'b0, 4'h0, 32'h0);

        // grant then reset on the next cycle: in-flight transfer must vanish
        step(1'b0, 4'b0010, 32'h0000_5500);
        step(1'b1, 4'hF, $urandom);
        repeat (8) step(1'b0, 4'hF, $urandom);

        // random traffic with occasional mid-stream resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0)
                step(1'b1, 4'($urandom_range(0, 15)), $urandom);
            else if (n < 750)
                step(1'b0, 4'($urandom_range(0, 15)), $urandom);
            else
                step(1'b0, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), $urandom);
        end
        repeat (6) step(1'b0, 4'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
